maze_mover: RTL
===============

# maze_mover

Parametrised player-movement controller for the maze game. Takes PS/2 make/break events for the four arrow keys and the generated maze bitmap (1 = open cell). It moves a player cursor one cell per step, with an immediate first step on press and auto-repeat while the key is held. It reports blocked attempts, counts moves and flags arrival at a goal cell. It sits between the keyboard decoder and the maze renderer, downstream of the maze generator.

## Interface
- COLS, 16: maze width in cells (2..256)
- ROWS, 16: maze height in cells (2..256)
- X_W, 4: width of x coordinates, ≥ clog2(COLS)
- Y_W, 4: width of y coordinates, ≥ clog2(ROWS)
- CNT_W, 12: move counter width
- REPEAT_TICKS, 10_000_000: clk cycles between auto-repeat steps (≥ 2)
- KEY_LEFT / KEY_RIGHT / KEY_UP / KEY_DOWN, 8'h6B / 8'h74 / 8'h75 / 8'h72: scan codes
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  game active; low forces IDLE and ignores key events
- start_load  in  1  sync pulse: load start position, clear stats
- key_valid  in  1  one-cycle strobe, key event present
- key_code  in  8  scan code of event
- key_release  in  1  1 = break (release), 0 = make (press); qualified by key_valid
- maze_data  in  COLS*ROWS  cell bitmap, bit index x + COLS*y, 1 = open
- start_x / start_y  in  X_W / Y_W  start cell
- goal_x / goal_y  in  X_W / Y_W  goal cell
- curr_x / curr_y  out  X_W / Y_W  registered player position
- moved  out  1  one-cycle pulse: a step committed
- bump  out  1  one-cycle pulse: a step was attempted and refused
- move_count  out  CNT_W  committed steps since load, saturating at all-ones
- at_goal  out  1  sticky: player on goal cell

## Operation
- Reset (async, reset_n=0): curr_x=0, curr_y=0, move_count=0, at_goal=0, moved=0, bump=0, held direction NONE, repeat counter 0, state IDLE.
- Priority per edge: reset_n > start_load > !enable > FSM.
- start_load: curr←start, move_count←0, at_goal←(start==goal), held NONE, state IDLE. Key events on the same edge are dropped.
- enable=0: state←IDLE, held←NONE. Position and stats are held. moved and bump are 0.
- Key events with enable=1 and not in DONE:
  - A make of an arrow code sets held to that direction and sets next state to STEP. This applies from any state and replaces any prior held direction.
  - A break of the held direction's code sets held to NONE and next state to IDLE.
  - A break of a non-held arrow, and any non-arrow code, is ignored.
- States:
  - IDLE: wait for a make.
  - STEP: evaluate one move in the held direction, then go to WAIT, or to DONE if the new position equals goal.
  - WAIT: count REPEAT_TICKS; at expiry go to STEP.
  - DONE: no moves, all keys ignored, until start_load.
- Move legality: the target is the neighbour cell.
  - The move is refused if it would leave the grid: left at x=0, right at x=COLS-1, up at y=0, down at y=ROWS-1.
  - The move is also refused if maze_data[target] = 0.
  - The edge check must gate the bitmap lookup. There is no coordinate wrap-around and no out-of-range index.
- Committed step: position updates, moved=1, and move_count increments (saturating).
- Refused step: position unchanged, bump=1, and auto-repeat continues to attempt, so bump pulses once per repeat.
- If a key event arrives on the same edge as a STEP evaluation, the in-flight step still commits with the old direction. The key event then decides the next state.

## Timing
- key_valid make sampled at edge T → STEP during cycle T..T+1 → position, moved/bump and move_count updated at edge T+1. Latency is one cycle after capture.
- While held, successive STEP evaluations are exactly REPEAT_TICKS cycles apart.
- A fresh make restarts the repeat timer: the immediate step is followed by a repeat REPEAT_TICKS cycles later.
- Break of the held key at edge B: no step commits after B unless one was already evaluated in cycle B-1..B.
- at_goal rises on the same edge the goal-reaching step commits.
- moved and bump are never both 1. Each is high for exactly one cycle per evaluation.
- maze_data, start_* and goal_* are sampled combinationally when used. They must be stable while enable=1.

## Test plan
- Reset then start_load with start=(1,1) and an all-open maze: expect curr=(1,1), move_count=0, at_goal=0, and no pulses.
- Make 0x74 at edge T: expect curr_x 1→2 at T+1 and moved for one cycle. Hold 3·REPEAT_TICKS cycles (REPEAT_TICKS=8 in bench): expect x=5, move_count=4.
- Start at (0,0) and press left, then up: expect bump pulses and position unchanged. Start at (COLS-1,0) and press right: expect bump, no wrap.
- Wall at bitmap bit (2+COLS*1)=0, start (1,1), press right: expect bump each REPEAT_TICKS and x stays 1. Release: expect no further pulses.
- Goal=(3,1), start (1,1), hold right: expect at_goal=1 when x=3, state DONE, and further makes ignored. start_load: expect at_goal=0, curr=start.
- Hold right, then make up without break: expect direction switches to up immediately. Then break right: expect it ignored. Deassert enable mid-WAIT: expect no steps until a new make.

Source files
------------

// File: rtl/maze_mover_if.sv
// Signal bundle between the maze controller (master side) and maze_mover
// (slave side): game control, key events, maze description and player state.
interface maze_mover_if #(
   parameter int COLS  = 16,
   parameter int ROWS  = 16,
   parameter int X_W   = 4,
   parameter int Y_W   = 4,
   parameter int CNT_W = 12
);

   // Game control
   logic                   enable;
   logic                   start_load;

   // Keyboard decoder events
   logic                   key_valid;
   logic [7:0]             key_code;
   logic                   key_release;

   // Maze description, stable while enable is high
   logic [COLS*ROWS-1:0]   maze_data;
   logic [X_W-1:0]         start_x;
   logic [Y_W-1:0]         start_y;
   logic [X_W-1:0]         goal_x;
   logic [Y_W-1:0]         goal_y;

   // Player state towards the renderer
   logic [X_W-1:0]         curr_x;
   logic [Y_W-1:0]         curr_y;
   logic                   moved;
   logic                   bump;
   logic [CNT_W-1:0]       move_count;
   logic                   at_goal;

   modport master (
      output enable, start_load,
      output key_valid, key_code, key_release,
      output maze_data, start_x, start_y, goal_x, goal_y,
      input  curr_x, curr_y, moved, bump, move_count, at_goal
   );

   modport slave (
      input  enable, start_load,
      input  key_valid, key_code, key_release,
      input  maze_data, start_x, start_y, goal_x, goal_y,
      output curr_x, curr_y, moved, bump, move_count, at_goal
   );

endinterface

// File: rtl/maze_mover.sv
// Player-movement controller for the maze game. Arrow-key make events give an
// immediate step followed by auto-repeat every REPEAT_TICKS cycles while the
// key is held. Moves are checked against the grid edge and the maze bitmap,
// refused moves pulse bump, committed moves pulse moved and bump the
// saturating move counter, and reaching the goal cell freezes the player.
module maze_mover #(
   parameter int         COLS         = 16,
   parameter int         ROWS         = 16,
   parameter int         X_W          = 4,
   parameter int         Y_W          = 4,
   parameter int         CNT_W        = 12,
   parameter int         REPEAT_TICKS = 10_000_000,
   parameter logic [7:0] KEY_LEFT     = 8'h6B,
   parameter logic [7:0] KEY_RIGHT    = 8'h74,
   parameter logic [7:0] KEY_UP       = 8'h75,
   parameter logic [7:0] KEY_DOWN     = 8'h72
) (
   input  logic        clk,
   input  logic        reset_n,
   maze_mover_if.slave bus
);

   localparam int CELLS = COLS * ROWS;
   localparam int IDX_W = $clog2(CELLS);
   localparam int RPT_W = $clog2(REPEAT_TICKS);

   // The WAIT state spans REPEAT_TICKS-1 cycles so that, together with the
   // STEP cycle, successive evaluations are exactly REPEAT_TICKS apart.
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS - 2);
   localparam logic [X_W-1:0]   X_LAST   = X_W'(COLS - 1);
   localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(ROWS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STEP,
      ST_WAIT,
      ST_DONE
   } state_t;

   typedef enum logic [2:0] {
      DIR_NONE,
      DIR_LEFT,
      DIR_RIGHT,
      DIR_UP,
      DIR_DOWN
   } dir_t;

   // Registered state
   state_t           state_q;
   dir_t             dir_q;
   logic [RPT_W-1:0] rpt_q;
   logic [X_W-1:0]   x_q;
   logic [Y_W-1:0]   y_q;
   logic [CNT_W-1:0] cnt_q;
   logic             at_goal_q;
   logic             moved_q;
   logic             bump_q;

   // Combinational decode of the current key event
   dir_t             key_dir;
   logic             key_make;
   logic             key_break_held;

   // Combinational evaluation of one step in the held direction
   logic [X_W-1:0]   tgt_x;
   logic [Y_W-1:0]   tgt_y;
   logic             in_grid;
   logic [IDX_W-1:0] cell_idx;
   logic             step_ok;
   logic [X_W-1:0]   new_x;
   logic [Y_W-1:0]   new_y;
   logic             reach_goal;

   // Map the scan code to a direction and classify the event
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the block leaves a signal unassigned and infers a latch.
      key_dir = DIR_NONE;
      if (bus.key_code == KEY_LEFT) begin
         key_dir = DIR_LEFT;
      end else if (bus.key_code == KEY_RIGHT) begin
         key_dir = DIR_RIGHT;
      end else if (bus.key_code == KEY_UP) begin
         key_dir = DIR_UP;
      end else if (bus.key_code == KEY_DOWN) begin
         key_dir = DIR_DOWN;
      end

      key_make       = bus.key_valid && !bus.key_release && (key_dir != DIR_NONE);
      key_break_held = bus.key_valid &&  bus.key_release && (key_dir != DIR_NONE)
                       && (key_dir == dir_q);
   end

   // Neighbour cell in the held direction; the grid-edge test decides whether
   // the bitmap is consulted at all, so the index never leaves the grid and
   // coordinates never wrap.
   always_comb begin
      tgt_x   = x_q;
      tgt_y   = y_q;
      in_grid = 1'b0;
      case (dir_q)
         DIR_LEFT: begin
            if (x_q != '0) begin
               in_grid = 1'b1;
               tgt_x   = x_q - 1'b1;
            end
         end
         DIR_RIGHT: begin
            if (x_q != X_LAST) begin
               in_grid = 1'b1;
               tgt_x   = x_q + 1'b1;
            end
         end
         DIR_UP: begin
            if (y_q != '0) begin
               in_grid = 1'b1;
               tgt_y   = y_q - 1'b1;
            end
         end
         DIR_DOWN: begin
            if (y_q != Y_LAST) begin
               in_grid = 1'b1;
               tgt_y   = y_q + 1'b1;
            end
         end
         default: begin
            in_grid = 1'b0;
         end
      endcase

      cell_idx   = IDX_W'(tgt_x) + IDX_W'(COLS) * IDX_W'(tgt_y);
      step_ok    = in_grid && bus.maze_data[cell_idx];
      new_x      = step_ok ? tgt_x : x_q;
      new_y      = step_ok ? tgt_y : y_q;
      reach_goal = (new_x == bus.goal_x) && (new_y == bus.goal_y);
   end

   // Movement FSM with registered position, statistics and pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // register samples the values from before this edge.
         state_q   <= ST_IDLE;
         dir_q     <= DIR_NONE;
         rpt_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         cnt_q     <= '0;
         at_goal_q <= 1'b0;
         moved_q   <= 1'b0;
         bump_q    <= 1'b0;
      end else if (bus.start_load) begin
         state_q   <= ST_IDLE;
         dir_q     <= DIR_NONE;
         rpt_q     <= '0;
         x_q       <= bus.start_x;
         y_q       <= bus.start_y;
         cnt_q     <= '0;
         at_goal_q <= (bus.start_x == bus.goal_x) && (bus.start_y == bus.goal_y);
         moved_q   <= 1'b0;
         bump_q    <= 1'b0;
      end else if (!bus.enable) begin
         // Game paused: position and statistics hold, a new make is needed
         state_q <= ST_IDLE;
         dir_q   <= DIR_NONE;
         rpt_q   <= '0;
         moved_q <= 1'b0;
         bump_q  <= 1'b0;
      end else begin
         moved_q <= 1'b0;
         bump_q  <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               state_q <= ST_IDLE;
            end
            ST_STEP: begin
               if (step_ok) begin
                  x_q     <= tgt_x;
                  y_q     <= tgt_y;
                  moved_q <= 1'b1;
                  if (cnt_q != '1) begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else begin
                  bump_q <= 1'b1;
               end
               rpt_q <= '0;
               if (reach_goal) begin
                  at_goal_q <= 1'b1;
                  state_q   <= ST_DONE;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (rpt_q == RPT_LAST) begin
                  state_q <= ST_STEP;
               end else begin
                  rpt_q <= rpt_q + 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_DONE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase

         // Key events override the next state, except once the game is over
         // (including the edge on which the goal-reaching step commits).
         if ((state_q != ST_DONE) && !((state_q == ST_STEP) && reach_goal)) begin
            if (key_make) begin
               dir_q   <= key_dir;
               state_q <= ST_STEP;
            end else if (key_break_held) begin
               dir_q   <= DIR_NONE;
               state_q <= ST_IDLE;
            end
         end
      end
   end

   // Drive the registered state onto the bus
   assign bus.curr_x     = x_q;
   assign bus.curr_y     = y_q;
   assign bus.moved      = moved_q;
   assign bus.bump       = bump_q;
   assign bus.move_count = cnt_q;
   assign bus.at_goal    = at_goal_q;

endmodule
